// File: rtl/sram_8kx8_fault_model.sv
// Synchronous single-port SRAM model with a programmable fault table
// (stuck-at-0/1, slow-to-rise), access counters and a fault-hit pulse.
module sram_8kx8_fault_model #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WE_WIDTH   = 1,
    parameter int unsigned NUM_FAULTS = 4,
    localparam int unsigned BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  b_clk,
    input  logic                  b_rst,
    input  logic                  cen,
    input  logic [WE_WIDTH-1:0]   wen,
    input  logic                  oen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  fi_wr,
    input  logic [3:0]            fi_idx,
    input  logic [1:0]            fi_type,
    input  logic [ADDR_WIDTH-1:0] fi_addr,
    input  logic [BIT_W-1:0]      fi_bit,
    output logic                  fault_hit,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned LANE_W = DATA_WIDTH / WE_WIDTH;

    localparam logic [1:0] FT_OFF = 2'b00;
    localparam logic [1:0] FT_SA0 = 2'b01;
    localparam logic [1:0] FT_SA1 = 2'b10;
    localparam logic [1:0] FT_STR = 2'b11;

    typedef struct packed {
        logic [1:0]            ftype;
        logic [ADDR_WIDTH-1:0] faddr;
        logic [BIT_W-1:0]      fbit;
    } fault_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    fault_t                ft  [NUM_FAULTS];

    logic                  rd_c;
    logic                  wr_c;
    logic                  hit_c;
    logic [DATA_WIDTH-1:0] mem_word_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] wr_word_c;
    logic [DATA_WIDTH-1:0] wmask_c;
    logic [1:0]            bit_type_c [DATA_WIDTH];

    assign rd_c       = !cen && (&wen);
    assign wr_c       = !cen && !(&wen);
    assign mem_word_c = mem[addr];

    // Per-bit winning fault type; scanning downward lets the lowest index win.
    always_comb begin
        hit_c = 1'b0;
        for (int b = 0; b < int'(DATA_WIDTH); b++) begin
            bit_type_c[b] = FT_OFF;
        end
        for (int i = int'(NUM_FAULTS) - 1; i >= 0; i--) begin
            if (ft[i].ftype != FT_OFF && ft[i].faddr == addr) begin
                hit_c                  = 1'b1;
                bit_type_c[ft[i].fbit] = ft[i].ftype;
            end
        end
    end

    // Lane-expanded active-high write mask.
    always_comb begin
        for (int b = 0; b < int'(DATA_WIDTH); b++) begin
            wmask_c[b] = ~|(wen & (WE_WIDTH'(1) << (b / int'(LANE_W))));
        end
    end

    // Faulted read word and faulted write-back word.
    always_comb begin
        rd_word_c = mem_word_c;
        wr_word_c = mem_word_c;
        for (int b = 0; b < int'(DATA_WIDTH); b++) begin
            case (bit_type_c[b])
                FT_SA0:  rd_word_c[b] = 1'b0;
                FT_SA1:  rd_word_c[b] = 1'b1;
                default: rd_word_c[b] = mem_word_c[b];
            endcase
            if (wmask_c[b]) begin
                case (bit_type_c[b])
                    FT_SA0:  wr_word_c[b] = 1'b0;
                    FT_SA1:  wr_word_c[b] = 1'b1;
                    FT_STR:  wr_word_c[b] = mem_word_c[b] & din[b];
                    default: wr_word_c[b] = din[b];
                endcase
            end
        end
    end

    // Array is never reset; writes are suppressed while reset is asserted.
    always_ff @(posedge b_clk) begin
        if (!b_rst && wr_c) begin
            mem[addr] <= wr_word_c;
        end
    end

    always_ff @(posedge b_clk) begin
        if (b_rst) begin
            dout      <= '0;
            fault_hit <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            for (int i = 0; i < int'(NUM_FAULTS); i++) begin
                ft[i] <= '0;
            end
        end else begin
            fault_hit <= rd_c && hit_c;
            if (rd_c) begin
                dout <= oen ? '0 : rd_word_c;
            end
            if (rd_c && rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr_c && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            // Out-of-range indices match no entry and are dropped.
            for (int i = 0; i < int'(NUM_FAULTS); i++) begin
                if (fi_wr && fi_idx == 4'(i)) begin
                    ft[i] <= '{ftype: fi_type, faddr: fi_addr, fbit: fi_bit};
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_8kx8_fault_model.sv
// Bench for sram_8kx8_fault_model: directed scenarios plus randomized traffic
// against a word-level reference model of memory, fault table and counters.
module tb_sram_8kx8_fault_model;

    localparam int NF = 4;

    logic        b_clk = 1'b0;
    logic        b_rst = 1'b1;
    logic        cen = 1'b1;
    logic [0:0]  wen = 1'b1;
    logic        oen = 1'b1;
    logic [12:0] addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        fi_wr = 1'b0;
    logic [3:0]  fi_idx = '0;
    logic [1:0]  fi_type = '0;
    logic [12:0] fi_addr = '0;
    logic [2:0]  fi_bit = '0;
    logic        fault_hit;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_mem  [8192];
    logic [1:0]  m_type [NF];
    logic [12:0] m_addr [NF];
    logic [2:0]  m_bit  [NF];
    logic [7:0]  exp_dout = '0;
    logic        exp_hit = 1'b0;
    int          exp_rd = 0;
    int          exp_wr = 0;

    always #5 b_clk = ~b_clk;

    sram_8kx8_fault_model dut (
        .b_clk(b_clk), .b_rst(b_rst), .cen(cen), .wen(wen), .oen(oen),
        .addr(addr), .din(din), .dout(dout), .fi_wr(fi_wr), .fi_idx(fi_idx),
        .fi_type(fi_type), .fi_addr(fi_addr), .fi_bit(fi_bit),
        .fault_hit(fault_hit), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    // Lowest-index enabled entry covering (a, b), or -1.
    function automatic int owner(input logic [12:0] a, input int b);
        for (int i = 0; i < NF; i++) begin
            if (m_type[i] != 2'd0 && m_addr[i] == a && int'(m_bit[i]) == b) return i;
        end
        return -1;
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic [7:0] v;
        int o;
        if (b_rst) begin
            exp_dout = '0; exp_hit = 1'b0; exp_rd = 0; exp_wr = 0;
            for (int i = 0; i < NF; i++) m_type[i] = 2'd0;
        end else begin
            exp_hit = 1'b0;
            if (!cen && wen == 1'b1) begin
                v = m_mem[addr];
                for (int b = 0; b < 8; b++) begin
                    o = owner(addr, b);
                    if (o >= 0 && m_type[o] == 2'd1) v[b] = 1'b0;
                    if (o >= 0 && m_type[o] == 2'd2) v[b] = 1'b1;
                end
                for (int i = 0; i < NF; i++)
                    if (m_type[i] != 2'd0 && m_addr[i] == addr) exp_hit = 1'b1;
                exp_dout = oen ? 8'h00 : v;
                if (exp_rd < 65535) exp_rd++;
            end else if (!cen) begin
                v = din;
                for (int b = 0; b < 8; b++) begin
                    o = owner(addr, b);
                    if (o >= 0 && m_type[o] == 2'd1) v[b] = 1'b0;
                    if (o >= 0 && m_type[o] == 2'd2) v[b] = 1'b1;
                    if (o >= 0 && m_type[o] == 2'd3 && !m_mem[addr][b] && din[b]) v[b] = 1'b0;
                end
                m_mem[addr] = v;
                if (exp_wr < 65535) exp_wr++;
            end
            if (fi_wr && int'(fi_idx) < NF) begin
                m_type[int'(fi_idx)] = fi_type;
                m_addr[int'(fi_idx)] = fi_addr;
                m_bit[int'(fi_idx)]  = fi_bit;
            end
        end
        @(posedge b_clk);
        #1;
    endtask

    task automatic op(input logic c, input logic w, input logic o,
                      input logic [12:0] a, input logic [7:0] d);
        @(negedge b_clk);
        b_rst = 1'b0; fi_wr = 1'b0;
        cen = c; wen = w; oen = o; addr = a; din = d;
        tick();
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        op(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [12:0] a, input logic o);
        op(1'b0, 1'b1, o, a, 8'h00);
    endtask

    task automatic idle();
        op(1'b1, 1'b1, 1'b1, 13'h0, 8'h00);
    endtask

    task automatic prog(input logic [3:0] idx, input logic [1:0] t,
                        input logic [12:0] a, input logic [2:0] bt);
        @(negedge b_clk);
        b_rst = 1'b0; cen = 1'b1; wen = 1'b1;
        fi_wr = 1'b1; fi_idx = idx; fi_type = t; fi_addr = a; fi_bit = bt;
        tick();
    endtask

    task automatic rst_cycle();
        @(negedge b_clk);
        b_rst = 1'b1; cen = 1'b1; wen = 1'b1; fi_wr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_cycle();
        rst_cycle();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", fault_hit); end
        checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL reset_rd_cnt: got %0d want 0", rd_cnt); end
        checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_basic();
        wr(13'h0010, 8'hA5);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL no_write_through: got %h want 00", dout); end
        checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL basic_wr_cnt: got %0d want 1", wr_cnt); end
        rd(13'h0010, 1'b0);
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_read: got %h want a5", dout); end
        checks++; if (rd_cnt !== 16'd1) begin errors++; $display("FAIL basic_rd_cnt: got %0d want 1", rd_cnt); end
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL basic_hit: got %b want 0", fault_hit); end
    endtask

    task automatic test_oen();
        wr(13'h1FFF, 8'h3C);
        rd(13'h1FFF, 1'b1);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL oen_high_read: got %h want 00", dout); end
        idle();
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL oen_idle_hold: got %h want 00", dout); end
        rd(13'h1FFF, 1'b0);
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL oen_low_read: got %h want 3c", dout); end
        idle();
        idle();
        checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL idle_hold: got %h want 3c", dout); end
    endtask

    task automatic test_stuck();
        prog(4'd0, 2'b10, 13'h0100, 3'd3);
        wr(13'h0100, 8'h00);
        rd(13'h0100, 1'b0);
        checks++; if (dout !== 8'h08) begin errors++; $display("FAIL sa1_read: got %h want 08", dout); end
        checks++; if (fault_hit !== 1'b1) begin errors++; $display("FAIL sa1_hit: got %b want 1", fault_hit); end
        idle();
        checks++; if (fault_hit !== 1'b0) begin errors++; $display("FAIL hit_pulse_width: got %b want 0", fault_hit); end
        wr(13'h0101, 8'h55);
        rd(13'h0101, 1'b0);
        checks++; if (dout !== 8'h55 || fault_hit !== 1'b0) begin
            errors++; $display("FAIL neighbour_read: got %h/%b want 55/0", dout, fault_hit); end
        // Entry written in the same cycle as a read must not affect that read.
        wr(13'h0200, 8'hFF);
        @(negedge b_clk);
        b_rst = 1'b0; cen = 1'b0; wen = 1'b1; oen = 1'b0; addr = 13'h0200;
        fi_wr = 1'b1; fi_idx = 4'd3; fi_type = 2'b01; fi_addr = 13'h0200; fi_bit = 3'd0;
        tick();
        checks++; if (dout !== 8'hFF || fault_hit !== 1'b0) begin
            errors++; $display("FAIL same_cycle_prog: got %h/%b want ff/0", dout, fault_hit); end
        rd(13'h0200, 1'b0);
        checks++; if (dout !== 8'hFE || fault_hit !== 1'b1) begin
            errors++; $display("FAIL sa0_next_cycle: got %h/%b want fe/1", dout, fault_hit); end
    endtask

    task automatic test_slow_rise();
        wr(13'h0005, 8'hFF);
        prog(4'd2, 2'b11, 13'h0005, 3'd0);
        wr(13'h0005, 8'h00);
        rd(13'h0005, 1'b0);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL str_fall_ok: got %h want 00", dout); end
        wr(13'h0005, 8'hFF);
        rd(13'h0005, 1'b0);
        checks++; if (dout !== 8'hFE) begin errors++; $display("FAIL str_rise_blocked: got %h want fe", dout); end
        wr(13'h0005, 8'h00);
        rd(13'h0005, 1'b0);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL str_write_zero: got %h want 00", dout); end
        prog(4'd1, 2'b10, 13'h0005, 3'd0);
        rd(13'h0005, 1'b0);
        checks++; if (dout !== 8'h01 || fault_hit !== 1'b1) begin
            errors++; $display("FAIL lowest_index_wins: got %h/%b want 01/1", dout, fault_hit); end
    endtask

    // MATS+ march over a window; returns the emulated BIST fail flag.
    task automatic run_march(output logic b_fail);
        b_fail = 1'b0;
        for (int a = 13'h0A80; a <= 13'h0AFF; a++) wr(13'(a), 8'h00);
        for (int a = 13'h0A80; a <= 13'h0AFF; a++) begin
            rd(13'(a), 1'b0);
            if (dout !== 8'h00) b_fail = 1'b1;
            wr(13'(a), 8'hFF);
        end
        for (int a = 13'h0AFF; a >= 13'h0A80; a--) begin
            rd(13'(a), 1'b0);
            if (dout !== 8'hFF) b_fail = 1'b1;
            wr(13'(a), 8'h00);
        end
    endtask

    task automatic test_march();
        logic b_fail;
        rst_cycle();
        run_march(b_fail);
        checks++; if (b_fail !== 1'b0) begin errors++; $display("FAIL march_clean: b_fail=%b want 0", b_fail); end
        prog(4'd0, 2'b01, 13'h0ABC, 3'd7);
        run_march(b_fail);
        checks++; if (b_fail !== 1'b1) begin errors++; $display("FAIL march_sa0: b_fail=%b want 1", b_fail); end
    endtask

    task automatic test_idx_drop();
        prog(4'd4, 2'b10, 13'h0040, 3'd0);
        prog(4'd15, 2'b10, 13'h0040, 3'd1);
        wr(13'h0040, 8'h00);
        rd(13'h0040, 1'b0);
        checks++; if (dout !== 8'h00 || fault_hit !== 1'b0) begin
            errors++; $display("FAIL idx_out_of_range: got %h/%b want 00/0", dout, fault_hit); end
    endtask

    task automatic test_reset_mid();
        prog(4'd0, 2'b10, 13'h0333, 3'd7);
        wr(13'h0333, 8'h11);
        rd(13'h0333, 1'b0);
        checks++; if (dout !== 8'h91) begin errors++; $display("FAIL sa1_on_write: got %h want 91", dout); end
        @(negedge b_clk);
        b_rst = 1'b1; fi_wr = 1'b0; cen = 1'b0; wen = 1'b1; oen = 1'b0; addr = 13'h0333;
        tick();
        checks++; if (dout !== 8'h00 || fault_hit !== 1'b0) begin
            errors++; $display("FAIL rst_mid_read: got %h/%b want 00/0", dout, fault_hit); end
        checks++; if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", rd_cnt, wr_cnt); end
        @(negedge b_clk);
        b_rst = 1'b1; cen = 1'b0; wen = 1'b0; addr = 13'h0333; din = 8'hEE;
        tick();
        rd(13'h0333, 1'b0);
        checks++; if (dout !== 8'h91 || fault_hit !== 1'b0) begin
            errors++; $display("FAIL rst_array_kept: got %h/%b want 91/0", dout, fault_hit); end
        checks++; if (rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_cnt_after: got %0d/%0d want 1/0", rd_cnt, wr_cnt); end
    endtask

    function automatic logic [12:0] pool_addr(input int j);
        return (j < 8) ? 13'(j) : 13'(13'h1FF8 + j - 8);
    endfunction

    task automatic test_random();
        rst_cycle();
        for (int j = 0; j < 16; j++) wr(pool_addr(j), 8'($urandom));
        for (int n = 0; n < 800; n++) begin
            @(negedge b_clk);
            b_rst   = ($urandom_range(0, 199) == 0);
            cen     = ($urandom_range(0, 3) == 0);
            wen     = 1'($urandom);
            oen     = ($urandom_range(0, 3) == 0);
            addr    = pool_addr(int'($urandom_range(0, 15)));
            din     = 8'($urandom);
            fi_wr   = ($urandom_range(0, 9) == 0);
            fi_idx  = 4'($urandom_range(0, 5));
            fi_type = 2'($urandom);
            fi_addr = pool_addr(int'($urandom_range(0, 15)));
            fi_bit  = 3'($urandom);
            tick();
            checks++; if (dout !== exp_dout) begin
                errors++; $display("FAIL rand_dout[%0d]: got %h want %h", n, dout, exp_dout); end
            checks++; if (fault_hit !== exp_hit) begin
                errors++; $display("FAIL rand_hit[%0d]: got %b want %b", n, fault_hit, exp_hit); end
            checks++; if (int'(rd_cnt) != exp_rd || int'(wr_cnt) != exp_wr) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                                   n, rd_cnt, wr_cnt, exp_rd, exp_wr); end
        end
    endtask

    initial begin
        for (int i = 0; i < NF; i++) begin
            m_type[i] = 2'd0; m_addr[i] = '0; m_bit[i] = '0;
        end
        test_reset();
        test_basic();
        test_oen();
        test_stuck();
        test_slow_rise();
        test_march();
        test_idx_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
